reg_alu_ctrl: RTL and testbench

REG_ALU_CTRL -- requirements
Module: reg_alu_ctrl

---
 rtl/reg_alu_ctrl.sv | 143 ++++++++++++++
 tb/tb_reg_alu_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_ctrl.sv
// Command sequencer for a register-file/ALU datapath: accepts LOAD/ALU/READ/NOP
// commands, drives datapath controls for one EXEC cycle and returns READ data.
module reg_alu_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_type,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_ra,
  input  logic [2:0]       cmd_rb,
  input  logic [2:0]       cmd_rd,
  input  logic [15:0]      cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             carry_flag,
  output logic [CNT_W-1:0] cmd_count,
  output logic             dp_sel,
  output logic             dp_wr,
  output logic [1:0]       dp_op,
  output logic [2:0]       dp_rd_addr_a,
  output logic [2:0]       dp_rd_addr_b,
  output logic [2:0]       dp_wr_addr,
  output logic [15:0]      dp_d_in,
  input  logic [15:0]      dp_d_out_a,
  input  logic             dp_cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] T_LOAD = 2'b00;
  localparam logic [1:0] T_ALU  = 2'b01;
  localparam logic [1:0] T_READ = 2'b10;
  localparam logic [1:0] T_NOP  = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [1:0]       op_q, op_d;
  logic [2:0]       ra_q, ra_d;
  logic [2:0]       rb_q, rb_d;
  logic [2:0]       rd_q, rd_d;
  logic [15:0]      imm_q, imm_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             carry_q, carry_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             exec_wr;

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    op_d       = op_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    rsp_data_d = rsp_data_q;
    carry_d    = carry_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;

    accept  = cmd_valid && (state_q == IDLE);
    exec_wr = (state_q == EXEC) && ((type_q == T_LOAD) || (type_q == T_ALU));

    if (accept) begin
      type_d = cmd_type;
      op_d   = cmd_op;
      ra_d   = cmd_ra;
      rb_d   = cmd_rb;
      rd_d   = cmd_rd;
      imm_d  = cmd_imm;
      cnt_d  = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        // NOP is counted and latched but never leaves IDLE, so NOPs stream back-to-back
        if (accept && (cmd_type != T_NOP)) state_d = EXEC;
      end
      EXEC: begin
        if (exec_wr) sel_d = (type_q == T_ALU);
        if (type_q == T_ALU) carry_d = dp_cout;
        if (type_q == T_READ) begin
          rsp_data_d = dp_d_out_a;
          state_d    = RESP;
        end else begin
          state_d    = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      type_q     <= T_LOAD;
      op_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      rsp_data_q <= '0;
      carry_q    <= 1'b0;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      op_q       <= op_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      rsp_data_q <= rsp_data_d;
      carry_q    <= carry_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
    end
  end

  // Write strobe decoded from state so an async reset kills it without waiting for a clock
  assign dp_wr        = exec_wr;
  assign dp_sel       = exec_wr ? (type_q == T_ALU) : sel_q;
  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_data     = rsp_data_q;
  assign carry_flag   = carry_q;
  assign cmd_count    = cnt_q;
  assign dp_op        = op_q;
  assign dp_rd_addr_a = ra_q;
  assign dp_rd_addr_b = rb_q;
  assign dp_wr_addr   = rd_q;
  assign dp_d_in      = imm_q;

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Directed bench for reg_alu_ctrl with a behavioural 8x16 register file / ALU.
module tb_reg_alu_ctrl;

  localparam logic [1:0] T_LOAD = 2'b00;
  localparam logic [1:0] T_ALU  = 2'b01;
  localparam logic [1:0] T_READ = 2'b10;
  localparam logic [1:0] T_NOP  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_ra, cmd_rb, cmd_rd;
  logic [15:0] cmd_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        carry_flag;
  logic [7:0]  cmd_count;
  logic        dp_sel, dp_wr;
  logic [1:0]  dp_op;
  logic [2:0]  dp_rd_addr_a, dp_rd_addr_b, dp_wr_addr;
  logic [15:0] dp_d_in;
  logic [15:0] dp_d_out_a;
  logic        dp_cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_alu_ctrl #(.CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_op       (cmd_op),
    .cmd_ra       (cmd_ra),
    .cmd_rb       (cmd_rb),
    .cmd_rd       (cmd_rd),
    .cmd_imm      (cmd_imm),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .carry_flag   (carry_flag),
    .cmd_count    (cmd_count),
    .dp_sel       (dp_sel),
    .dp_wr        (dp_wr),
    .dp_op        (dp_op),
    .dp_rd_addr_a (dp_rd_addr_a),
    .dp_rd_addr_b (dp_rd_addr_b),
    .dp_wr_addr   (dp_wr_addr),
    .dp_d_in      (dp_d_in),
    .dp_d_out_a   (dp_d_out_a),
    .dp_cout      (dp_cout)
  );

  // Datapath model: ops add, sub, and, xor; carry from the 17-bit add/sub result
  logic [15:0] regs [8];
  logic [15:0] op_a, op_b;
  logic [16:0] alu_full;

  initial for (int i = 0; i < 8; i++) regs[i] = 16'h0000;

  always_comb begin
    op_a = regs[dp_rd_addr_a];
    op_b = regs[dp_rd_addr_b];
    case (dp_op)
      2'b00:   alu_full = {1'b0, op_a} + {1'b0, op_b};
      2'b01:   alu_full = {1'b0, op_a} + {1'b0, ~op_b} + 17'd1;
      2'b10:   alu_full = {1'b0, op_a & op_b};
      default: alu_full = {1'b0, op_a ^ op_b};
    endcase
  end

  assign dp_d_out_a = op_a;
  assign dp_cout    = alu_full[16];

  always @(posedge clk) if (dp_wr) regs[dp_wr_addr] <= dp_sel ? alu_full[15:0] : dp_d_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [1:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rd, input logic [15:0] imm);
    cmd_type  = t;
    cmd_op    = op;
    cmd_ra    = ra;
    cmd_rb    = rb;
    cmd_rd    = rd;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_wr"},    {31'd0, dp_wr}, 32'd0);
    check({tag, "_sel"},   {31'd0, dp_sel}, 32'd0);
    check({tag, "_rspv"},  {31'd0, rsp_valid}, 32'd0);
    check({tag, "_carry"}, {31'd0, carry_flag}, 32'd0);
    check({tag, "_cnt"},   {24'd0, cmd_count}, 32'd0);
    check({tag, "_rspd"},  {16'd0, rsp_data}, 32'd0);
    check({tag, "_dp"},    {11'd0, dp_op, dp_rd_addr_a, dp_rd_addr_b, dp_wr_addr, dp_d_in}, 32'd0);
  endtask

  int wr_seen;
  int not_ready;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = T_NOP;
    cmd_op    = 2'b00;
    cmd_ra    = 3'd0;
    cmd_rb    = 3'd0;
    cmd_rd    = 3'd0;
    cmd_imm   = 16'h0000;
    rsp_ready = 1'b0;
    #1 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step();

    // LOAD r3 = 0x1234
    issue(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd3, 16'h1234);
    check("ld_wr",    {31'd0, dp_wr}, 32'd1);
    check("ld_sel",   {31'd0, dp_sel}, 32'd0);
    check("ld_addr",  {29'd0, dp_wr_addr}, 32'd3);
    check("ld_din",   {16'd0, dp_d_in}, 32'h1234);
    check("ld_ready", {31'd0, cmd_ready}, 32'd0);
    check("ld_cnt",   {24'd0, cmd_count}, 32'd1);
    step();
    check("ld_wr_off", {31'd0, dp_wr}, 32'd0);
    check("ld_rdy_on", {31'd0, cmd_ready}, 32'd1);
    check("ld_r3",     {16'd0, regs[3]}, 32'h1234);
    check("ld_hold",   {29'd0, dp_wr_addr}, 32'd3);

    // r1 = 0xFFFF, r2 = 1, r4 = r1 + r2 -> 0 with carry
    issue(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd1, 16'hFFFF);
    step();
    issue(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd2, 16'h0001);
    step();
    issue(T_ALU, 2'b00, 3'd1, 3'd2, 3'd4, 16'h0000);
    check("add_wr",     {31'd0, dp_wr}, 32'd1);
    check("add_sel",    {31'd0, dp_sel}, 32'd1);
    check("add_c_pre",  {31'd0, carry_flag}, 32'd0);
    step();
    check("add_carry",  {31'd0, carry_flag}, 32'd1);
    check("add_wr_off", {31'd0, dp_wr}, 32'd0);
    check("add_selhld", {31'd0, dp_sel}, 32'd1);
    check("add_r4",     {16'd0, regs[4]}, 32'h0000);
    check("add_cnt",    {24'd0, cmd_count}, 32'd4);

    // READ r4 with rsp_ready held low for three RESP cycles
    issue(T_READ, 2'b00, 3'd4, 3'd0, 3'd0, 16'h0000);
    check("rd_ex_wr",   {31'd0, dp_wr}, 32'd0);
    check("rd_ex_rspv", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_wait_v", {31'd0, rsp_valid}, 32'd1);
      check("rd_wait_d", {16'd0, rsp_data}, 32'h0000);
      check("rd_wait_r", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rd_done_v", {31'd0, rsp_valid}, 32'd0);
    check("rd_done_r", {31'd0, cmd_ready}, 32'd1);
    check("rd_carry",  {31'd0, carry_flag}, 32'd1);
    check("rd_cnt",    {24'd0, cmd_count}, 32'd5);

    // READ r1 with rsp_ready already high: completes on the first RESP edge
    rsp_ready = 1'b1;
    issue(T_READ, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0000);
    step();
    check("rd1_v",    {31'd0, rsp_valid}, 32'd1);
    check("rd1_data", {16'd0, rsp_data}, 32'hFFFF);
    step();
    rsp_ready = 1'b0;
    check("rd1_done", {31'd0, rsp_valid}, 32'd0);
    check("rd1_hold", {16'd0, rsp_data}, 32'hFFFF);

    // ALU and: r5 = r1 & r3 = 0x1234, carry clears
    issue(T_ALU, 2'b10, 3'd1, 3'd3, 3'd5, 16'h0000);
    step();
    check("and_r5",    {16'd0, regs[5]}, 32'h1234);
    check("and_carry", {31'd0, carry_flag}, 32'd0);
    check("and_rspd",  {16'd0, rsp_data}, 32'hFFFF);

    // cmd_valid held high through EXEC of a LOAD
    cmd_type = T_LOAD; cmd_op = 2'b00; cmd_ra = 3'd0; cmd_rb = 3'd0;
    cmd_rd = 3'd6; cmd_imm = 16'hBEEF; cmd_valid = 1'b1;
    step();
    check("hld_ld_wr", {31'd0, dp_wr}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check("hld_ld_cnt", {24'd0, cmd_count}, 32'd8);
    check("hld_ld_r6",  {16'd0, regs[6]}, 32'hBEEF);

    // cmd_valid held high through EXEC and RESP of a READ; fields changed mid-way are ignored
    cmd_type = T_READ; cmd_ra = 3'd6; cmd_valid = 1'b1;
    step();
    step();
    cmd_ra = 3'd7; cmd_type = T_LOAD; cmd_rd = 3'd7;
    step();
    check("hld_rd_v",    {31'd0, rsp_valid}, 32'd1);
    check("hld_rd_addr", {29'd0, dp_rd_addr_a}, 32'd6);
    check("hld_rd_cnt",  {24'd0, cmd_count}, 32'd9);
    check("hld_rd_data", {16'd0, rsp_data}, 32'hBEEF);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("hld_rd_done", {31'd0, rsp_valid}, 32'd0);
    check("hld_rd_cnt2", {24'd0, cmd_count}, 32'd9);

    // 256 back-to-back NOPs: count wraps, no writes, ready never drops
    wr_seen   = 0;
    not_ready = 0;
    cmd_type = T_NOP; cmd_op = 2'b00; cmd_ra = 3'd0; cmd_rb = 3'd0;
    cmd_rd = 3'd0; cmd_imm = 16'h0000; cmd_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step();
      if (dp_wr) wr_seen++;
      if (!cmd_ready) not_ready++;
      if (i == 246) check("nop_wrap0", {24'd0, cmd_count}, 32'd0);
    end
    cmd_valid = 1'b0;
    check("nop_cnt",   {24'd0, cmd_count}, 32'd9);
    check("nop_wr",    wr_seen, 32'd0);
    check("nop_ready", not_ready, 32'd0);

    // Reset asserted mid-EXEC of ALU r3 = r1 + r2
    issue(T_ALU, 2'b00, 3'd1, 3'd2, 3'd3, 16'h0000);
    check("rst_ex_wr", {31'd0, dp_wr}, 32'd1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_ex");
    step();
    check("rst_ex_r3", {16'd0, regs[3]}, 32'h1234);
    check("rst_ex_wr2", {31'd0, dp_wr}, 32'd0);
    @(negedge clk) reset = 1'b1;
    step();

    // Reset asserted in RESP
    issue(T_READ, 2'b00, 3'd3, 3'd0, 3'd0, 16'h0000);
    step();
    check("rst_rs_v", {31'd0, rsp_valid}, 32'd1);
    check("rst_rs_d", {16'd0, rsp_data}, 32'h1234);
    #1 reset = 1'b0;
    #1 check("rst_rs_v0", {31'd0, rsp_valid}, 32'd0);
    check("rst_rs_d0", {16'd0, rsp_data}, 32'd0);
    @(negedge clk) reset = 1'b1;
    step();

    // Operation resumes normally after reset
    issue(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd7, 16'h00AA);
    check("post_cnt", {24'd0, cmd_count}, 32'd1);
    step();
    check("post_r7", {16'd0, regs[7]}, 32'h00AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
